// File: rtl/tdm_demux8.sv
// Registered 1-to-8 TDM demultiplexer: collects framed serial bits into a shadow
// word and publishes it on out_word only when all slots of a frame have arrived.

module tdm_slot_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic wr_en,
    input  logic d,
    output logic q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     q <= 1'b0;
        else if (wr_en) q <= d;
    end
endmodule

module tdm_demux8 #(
    parameter int N_CH  = 8,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_bit,
    input  logic             in_valid,
    input  logic             frame_start,
    output logic [N_CH-1:0]  out_word,
    output logic             out_valid,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic             frame_err,
    output logic [7:0]       frame_cnt
);
    typedef enum logic {IDLE, COLLECT} state_t;

    state_t          state;
    logic [N_CH-1:0] shadow;
    logic [N_CH-1:0] slot_wr;
    logic            take_start;
    logic            take_data;
    logic            last_slot;

    assign take_start = in_valid && frame_start;
    assign take_data  = in_valid && !frame_start && (state == COLLECT);
    assign last_slot  = take_data && (sel == SEL_W'(N_CH - 1));

    // A frame_start always lands in slot 0, whether it opens or restarts a frame.
    always_comb begin
        slot_wr = '0;
        if (take_start)
            slot_wr[0] = 1'b1;
        else if (take_data)
            slot_wr[sel] = 1'b1;
    end

    genvar k;
    generate
        for (k = 0; k < N_CH; k++) begin : g_slot
            tdm_slot_cell u_cell (
                .clk   (clk),
                .rst_n (rst_n),
                .wr_en (slot_wr[k]),
                .d     (in_bit),
                .q     (shadow[k])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_word  <= '0;
            out_valid <= 1'b0;
            sel       <= '0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
            frame_cnt <= '0;
        end else begin
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (take_start) begin
                        state <= COLLECT;
                        busy  <= 1'b1;
                        sel   <= SEL_W'(1);
                    end
                end
                COLLECT: begin
                    if (take_start) begin
                        frame_err <= 1'b1;
                        sel       <= SEL_W'(1);
                    end else if (last_slot) begin
                        // The final bit bypasses the shadow so the word is out one edge sooner.
                        out_word  <= {in_bit, shadow[N_CH-2:0]};
                        out_valid <= 1'b1;
                        frame_cnt <= frame_cnt + 8'd1;
                        sel       <= '0;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end else if (take_data) begin
                        sel <= sel + SEL_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    sel   <= '0;
                end
            endcase
        end
    end
endmodule

// File: doc/tdm_demux8.md
Name: tdm_demux8

Overview:
- Receive-side counterpart of the 8:1 mux tree: a registered time-division 1-to-8 demultiplexer / deserializer.
- Accepts the serial bit stream produced by scanning an 8:1 mux with sel = 0..7, one bit per valid cycle, framed by a start marker.
- Reassembles the bits into an 8-bit parallel word so that bit k lands in out_word[k], matching mux sel = k selecting in[k].
- Sits at the far end of a serial link or scan path; feeds parallel consumers with a one-cycle valid strobe.

Parameters:
- N_CH, 8, number of channels/slots per frame; fixed at 8 for this revision, and the RTL only needs to support 8.
- SEL_W, 3, width of the slot index; equals clog2(N_CH).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_bit  input  1  serial data bit for the current slot.
- in_valid  input  1  in_bit and frame_start are sampled only when high.
- frame_start  input  1  marks in_bit as slot 0 of a new frame; qualified by in_valid.
- out_word  output  8  last completely received frame; out_word[k] = slot k.
- out_valid  output  1  one-cycle pulse when out_word has just been updated.
- sel  output  3  slot index the next accepted bit will be written to; 0 in IDLE.
- busy  output  1  high while a frame is partially collected (state COLLECT).
- frame_err  output  1  one-cycle pulse when a partial frame is aborted.
- frame_cnt  output  8  count of completed frames; wraps 255 -> 0.

Behaviour:
- Reset, asynchronous on rst_n low:
  - state = IDLE.
  - out_word, sel, frame_cnt = 0.
  - out_valid, busy, frame_err = 0.
  - Internal shadow register cleared.
- Reset mid-frame discards the partial frame with no error pulse.
- Shadow register collects the bits; out_word is written only on frame completion, so partial data is never visible on out_word.
- States: IDLE, COLLECT.
- IDLE:
  - in_valid && frame_start: shadow[0] = in_bit, sel -> 1, go to COLLECT.
  - in_valid && !frame_start: bit dropped silently, no error, stay IDLE.
  - in_valid low: hold.
- COLLECT:
  - in_valid low: hold everything; gaps of any length are allowed.
  - in_valid && !frame_start: shadow[sel] = in_bit, sel increments.
  - When the bit for slot 7 is accepted:
    - Next edge: out_word = completed shadow including this bit.
    - out_valid = 1 for exactly one cycle.
    - frame_cnt += 1, mod 256.
    - sel -> 0, state -> IDLE.
  - in_valid && frame_start at any slot 1..7 (abort/restart):
    - Partial frame discarded; out_word and frame_cnt unchanged.
    - frame_err = 1 for one cycle.
    - The bit is taken as slot 0 of a new frame: shadow[0] = in_bit, sel -> 1, stay in COLLECT.
- Latency: out_valid is asserted in the cycle after the edge that samples slot 7.
  - Minimum frame period is 8 cycles.
  - A frame_start in the cycle after completion (state IDLE) is accepted with zero bubble, so back-to-back frames are supported.
- frame_err and out_valid are never high in the same cycle.
- busy = (state == COLLECT).
- sel wraps only through the completion path, never past 7.
- All outputs are registered; no combinational path from the inputs to the outputs.

Test Plan:
- Reset, then frame_start with bits 1,0,1,1,0,0,1,0 over 8 consecutive valid cycles -> out_word = 8'h4D and out_valid pulses once, 1 cycle after slot 7; frame_cnt = 1; sel back to 0.
- Same frame with in_valid low for 3 cycles after slot 3 -> out_word = 8'h4D still; sel holds at 4 during the gap; busy stays high.
- Frame A = 8'hA5 immediately followed by a frame_start for frame B = 8'h3C -> two out_valid pulses 8 cycles apart; out_word = 8'hA5 then 8'h3C; frame_cnt = 2.
- 5 bits of a frame, then a new frame_start with frame 8'hFF -> frame_err pulses once at the restart; out_word shows only 8'hFF; frame_cnt increments by 1 only.
- Valid bits sent in IDLE without frame_start -> no out_valid, no frame_err; out_word unchanged.
- rst_n low asynchronously mid-frame (slot 4), released, then a full frame 8'h81 -> outputs are 0 immediately on reset; after release only 8'h81 is delivered; frame_cnt = 1.
- 256 complete frames -> frame_cnt wraps to 0.
